simd_dot_acc: RTL



---
 rtl/simd_dot_acc_pkg.sv | 15 +
 rtl/simd_lane_acc.sv | 45 ++++
 rtl/simd_dot_acc.sv | 109 ++++++++++
 3 files changed

// File: rtl/simd_dot_acc_pkg.sv
// Shared constants and controller state type for the SIMD dot-product accumulator.
// Lane layout matches the packed 45-bit output of the 9x9 multiplier array.
package pirdsp_simd_pkg;

    localparam int LANE_HI_W   = 21;
    localparam int LANE_LO_W   = 24;
    localparam int LANE_HI_LSB = 24;
    localparam int PACK_W      = 45;

    typedef enum logic {
        ACC,
        HOLD
    } acc_state_t;

endpackage

// File: rtl/simd_lane_acc.sv
// One signed accumulator lane: sign-extend, add, detect overflow, optional clamp, sticky flag.
// sum/ovf present the group value including the current beat, for capture on the last beat.
module simd_lane_acc #(
    parameter int IN_W  = 24,
    parameter int ACC_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] raw;
    logic                    acc_ovf;
    logic                    hit;

    always_comb begin
        ext = ACC_W'(din);
        raw = acc + ext;
        // Overflow only when both operands agree in sign and the result does not.
        hit = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
        sum = raw;
        if (SAT && hit) begin
            sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        ovf = acc_ovf | hit;
    end

    always_ff @(posedge clk) begin
        if (rst || (en && clr)) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (en) begin
            acc     <= sum;
            acc_ovf <= ovf;
        end
    end

endmodule

// File: rtl/simd_dot_acc.sv
// Two-lane dot-product accumulator behind the SIMD multiplier array.
// Groups end on in_last; totals are held in an output register under valid/ready.
module simd_dot_acc
    import pirdsp_simd_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PACK_W-1:0]       in_y,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_hi,
    output logic signed [ACC_W-1:0] out_lo,
    output logic [CNT_W-1:0]        out_cnt,
    output logic [1:0]              out_ovf
);

    acc_state_t              state;
    acc_state_t              nxt;
    logic                    take;
    logic                    fin;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic signed [ACC_W-1:0] sum_hi;
    logic signed [ACC_W-1:0] sum_lo;
    logic                    ovf_hi;
    logic                    ovf_lo;

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign take      = in_valid && in_ready;
    assign fin       = take && in_last;
    assign cnt_nxt   = (&cnt) ? cnt : cnt + 1'b1;

    simd_lane_acc #(
        .IN_W  (LANE_HI_W),
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_hi (
        .clk (clk),
        .rst (rst),
        .en  (take),
        .clr (in_last),
        .din (in_y[PACK_W-1:LANE_HI_LSB]),
        .sum (sum_hi),
        .ovf (ovf_hi)
    );

    simd_lane_acc #(
        .IN_W  (LANE_LO_W),
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_lo (
        .clk (clk),
        .rst (rst),
        .en  (take),
        .clr (in_last),
        .din (in_y[LANE_LO_W-1:0]),
        .sum (sum_lo),
        .ovf (ovf_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= nxt;
        end
    end

    // A last beat can only be taken in HOLD when out_ready is high, so HOLD reloads in place.
    always_comb begin
        nxt = state;
        case (state)
            ACC:     if (fin) nxt = HOLD;
            HOLD:    if (out_ready) nxt = fin ? HOLD : ACC;
            default: nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || fin) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hi  <= '0;
            out_lo  <= '0;
            out_cnt <= '0;
            out_ovf <= '0;
        end else if (fin) begin
            out_hi  <= sum_hi;
            out_lo  <= sum_lo;
            out_cnt <= cnt_nxt;
            out_ovf <= {ovf_hi, ovf_lo};
        end
    end

endmodule
